kbd_serial_tx: RTL

- Keyboard-side transmitter for the CIA serial port, i.e. the device on the other end of CNT/SP when the CIA is in input mode (CRA[6]=0).
- Sends one byte per request using the keyboard framing: rotate left by one, bits active-low on the line, MSB first, CIA shifting on the rising CNT edge.
- After the frame, it waits for the host handshake, where the CIA pulls SP low and then releases it.
- Used as the bench/peripheral model and as a synthesizable keyboard controller core.

---
 rtl/kbd_serial_tx_if.sv | 23 ++
 rtl/kbd_serial_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/kbd_serial_tx_if.sv
// Request, status and open-drain line signals between a keyboard transmitter and its user.
// The master side owns the byte request and the observed SP level. The slave side owns status and line enables.
interface kbd_serial_tx_if;
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;
   logic       BUSY;
   logic       DONE;
   logic       TIMEOUT;
   logic       CNT_DRV;
   logic       SP_DRV;
   logic       SP_IN;

   modport master (
      output TX_DATA, TX_VALID, SP_IN,
      input  TX_READY, BUSY, DONE, TIMEOUT, CNT_DRV, SP_DRV
   );

   modport slave (
      input  TX_DATA, TX_VALID, SP_IN,
      output TX_READY, BUSY, DONE, TIMEOUT, CNT_DRV, SP_DRV
   );
endinterface

// File: rtl/kbd_serial_tx.sv
// Keyboard-side CIA serial transmitter: one rotated, active-low byte per request, MSB first, then host SP handshake.
// Line enables and status are decoded from the state register only, so a reset releases CNT/SP in the same cycle.
module kbd_serial_tx #(
   parameter int SETUP_CYC   = 20,
   parameter int LOW_CYC     = 20,
   parameter int HIGH_CYC    = 20,
   parameter int TIMEOUT_CYC = 143000
) (
   input  logic            CLK,
   input  logic            RESET,
   kbd_serial_tx_if.slave  tx
);
   localparam int MAX_A = (SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC;
   localparam int MAX_B = (HIGH_CYC > TIMEOUT_CYC) ? HIGH_CYC : TIMEOUT_CYC;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TW    = $clog2(MAX_P) + 1;

   localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] LOW_LAST   = TW'(LOW_CYC - 1);
   localparam logic [TW-1:0] HIGH_LAST  = TW'(HIGH_CYC - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] ACK_BLANK  = TW'(3);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      CLK_LOW,
      CLK_HIGH,
      ACK_WAIT,
      ACK_RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          sp_meta_q, sp_meta_d;
   logic          sp_s_q, sp_s_d;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
         timer_q   <= '0;
         sp_meta_q <= 1'b1;
         sp_s_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         timer_q   <= timer_d;
         sp_meta_q <= sp_meta_d;
         sp_s_q    <= sp_s_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      timer_d     = timer_q + TW'(1);
      sp_meta_d   = tx.SP_IN;
      sp_s_d      = sp_meta_q;
      tx.TX_READY = 1'b0;
      tx.BUSY     = 1'b1;
      tx.DONE     = 1'b0;
      tx.TIMEOUT  = 1'b0;
      tx.CNT_DRV  = 1'b0;
      tx.SP_DRV   = 1'b0;

      case (state_q)
         IDLE: begin
            tx.TX_READY = 1'b1;
            tx.BUSY     = 1'b0;
            timer_d     = '0;
            if (tx.TX_VALID) begin
               shreg_d  = {tx.TX_DATA[6:0], tx.TX_DATA[7]};
               bitcnt_d = '0;
               state_d  = SETUP;
            end
         end

         SETUP: begin
            tx.SP_DRV = shreg_q[7];
            if (timer_q == SETUP_LAST) begin
               timer_d = '0;
               state_d = CLK_LOW;
            end
         end

         CLK_LOW: begin
            tx.SP_DRV  = shreg_q[7];
            tx.CNT_DRV = 1'b1;
            if (timer_q == LOW_LAST) begin
               timer_d = '0;
               state_d = CLK_HIGH;
            end
         end

         CLK_HIGH: begin
            // Data is still held here: the CIA samples on the rising CNT edge that opens this phase.
            tx.SP_DRV = shreg_q[7];
            if (timer_q == HIGH_LAST) begin
               timer_d = '0;
               if (bitcnt_q == 3'd7) begin
                  state_d = ACK_WAIT;
               end else begin
                  shreg_d  = {shreg_q[6:0], 1'b0};
                  bitcnt_d = bitcnt_q + 3'd1;
                  state_d  = SETUP;
               end
            end
         end

         ACK_WAIT: begin
            // The first cycles still see our own last bit through the synchronizer, so they are blanked.
            if (timer_q == TO_LAST) begin
               tx.TIMEOUT = 1'b1;
               timer_d    = '0;
               state_d    = IDLE;
            end else if (timer_q >= ACK_BLANK && !sp_s_q) begin
               state_d = ACK_RELEASE;
            end
         end

         ACK_RELEASE: begin
            // The timer carries over from ACK_WAIT so the timeout bounds the whole handshake.
            if (sp_s_q) begin
               tx.DONE = 1'b1;
               timer_d = '0;
               state_d = IDLE;
            end else if (timer_q == TO_LAST) begin
               tx.TIMEOUT = 1'b1;
               timer_d    = '0;
               state_d    = IDLE;
            end
         end

         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase
   end
endmodule
